score_display: RTL and testbench

//  Downstream consumer of the 32-bit game score. Clamps the score to 4 decimal digits and converts it
//  to BCD with an iterative double-dabble engine, then drives the board's 4-digit multiplexed 7-segment display.

---
 rtl/score_pkg.sv | 46 ++++
 rtl/score_display_if.sv | 13 +
 rtl/score_display_bin2bcd_iter.sv | 75 +++++++
 rtl/score_display.sv | 105 ++++++++++
 tb/tb_score_display.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_pkg.sv
// Shared constants for the score display: segment encodings, digit geometry,
// converter state type and the digit-to-segment decode.
package score_pkg;

  localparam int DIGITS = 4;
  localparam int BCD_W  = 16;
  localparam int CONV_W = 14;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/score_display_if.sv
// Score input and 7-segment pin bundle between the score counter side and the display.
interface score_display_if #(
  parameter int SCORE_W = 32
);
  logic [SCORE_W-1:0] score;
  logic [6:0]         seg;
  logic               dp;
  logic [3:0]         an;
  logic               overflow;

  modport master (output score, input seg, dp, an, overflow);
  modport slave  (input score, output seg, dp, an, overflow);
endinterface

// File: rtl/score_display_bin2bcd_iter.sv
// Iterative double-dabble: one shift per cycle, 14-bit binary in, 4 BCD nibbles out.
// state    | meaning
// ST_IDLE  | waiting for start, bcd holds last result
// ST_SHIFT | add-3 then shift, 14 cycles counted by cnt 13..0
// ST_DONE  | result stable on bcd, done high for this cycle
module bin2bcd_iter
  import score_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CONV_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  conv_state_t       state;
  logic [CONV_W-1:0] bin_sr;
  logic [BCD_W-1:0]  acc;
  logic [BCD_W-1:0]  acc_adj;
  logic [3:0]        cnt;

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      bin_sr <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            bin_sr <= bin;
            acc    <= '0;
            cnt    <= 4'(CONV_W - 1);
            busy   <= 1'b1;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc    <= {acc_adj[BCD_W-2:0], bin_sr[CONV_W-1]};
          bin_sr <= {bin_sr[CONV_W-2:0], 1'b0};
          cnt    <= cnt - 4'd1;
          if (cnt == 4'd0) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bcd = acc;

endmodule

// File: rtl/score_display.sv
// Clamps the captured score to MAX_SHOWN, converts it to BCD and scans it onto a
// 4-digit multiplexed active-low 7-segment display with leading-zero blanking.
module score_display
  import score_pkg::*;
#(
  parameter int SCORE_W     = 32,
  parameter int MAX_SHOWN   = 9999,
  parameter int REFRESH_DIV = 100000
) (
  input logic            clk,
  input logic            reset,
  score_display_if.slave bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] src_q;
  logic               ovf_pend;
  logic [BCD_W-1:0]   bcd_q;
  logic               overflow;
  logic [CNT_W-1:0]   refresh_cnt;
  logic [1:0]         digit_idx;
  logic [6:0]         seg_r;
  logic [3:0]         an_r;

  logic               is_over;
  logic [CONV_W-1:0]  conv_in;
  logic               conv_start;
  logic               conv_busy;
  logic               conv_done;
  logic [BCD_W-1:0]   conv_bcd;

  logic [3:0]         cur_digit;
  logic [BCD_W-1:0]   upper_digits;
  logic [6:0]         seg_next;

  // Clamp decision is made at full width so large scores never alias into 14 bits
  assign is_over    = score_q > SCORE_W'(MAX_SHOWN);
  assign conv_in    = is_over ? CONV_W'(MAX_SHOWN) : score_q[CONV_W-1:0];
  assign conv_start = !conv_busy && (score_q != src_q);

  bin2bcd_iter u_conv (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (conv_in),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      score_q  <= '0;
      src_q    <= '0;
      ovf_pend <= 1'b0;
      bcd_q    <= '0;
      overflow <= 1'b0;
    end else begin
      score_q <= bus.score;
      if (conv_start) begin
        src_q    <= score_q;
        ovf_pend <= is_over;
      end
      // Digits and overflow flag commit together so no partial value is ever scanned
      if (conv_done) begin
        bcd_q    <= conv_bcd;
        overflow <= ovf_pend;
      end
    end
  end

  assign cur_digit    = bcd_q[{digit_idx, 2'b00} +: 4];
  assign upper_digits = bcd_q >> {digit_idx, 2'b00};

  always_comb begin
    seg_next = seg_decode(cur_digit);
    if (digit_idx != 2'd0 && upper_digits == '0) seg_next = SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      an_r        <= 4'b1110;
      seg_r       <= SEG_0;
    end else begin
      if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      an_r  <= ~(4'b0001 << digit_idx);
      seg_r <= seg_next;
    end
  end

  assign bus.seg      = seg_r;
  assign bus.an       = an_r;
  assign bus.dp       = 1'b1;
  assign bus.overflow = overflow;

endmodule

// File: tb/tb_score_display.sv
// Randomized self-checking bench for score_display against a decimal-arithmetic reference model.
module tb_score_display;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  score_display_if #(.SCORE_W(32)) bus ();

  score_display #(.SCORE_W(32), .MAX_SHOWN(9999), .REFRESH_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int unsigned pow10 [4]    = '{1, 10, 100, 1000};

  function automatic int unsigned clamp_val(input logic [31:0] s);
    return (s > 32'd9999) ? 9999 : int'(s);
  endfunction

  function automatic logic [15:0] model_bcd(input logic [31:0] s);
    int unsigned v;
    logic [15:0] r;
    v = clamp_val(s);
    r = '0;
    for (int d = 0; d < 4; d++) r[4*d +: 4] = 4'((v / pow10[d]) % 10);
    return r;
  endfunction

  function automatic logic [27:0] model_segs(input logic [31:0] s);
    int unsigned v;
    logic [27:0] r;
    v = clamp_val(s);
    for (int d = 0; d < 4; d++) begin
      if (d > 0 && v < pow10[d]) r[7*d +: 7] = 7'h7F;
      else                       r[7*d +: 7] = seg_tab[(v / pow10[d]) % 10];
    end
    return r;
  endfunction

  // Observes one full 16-cycle scan period; collects seg per digit and slot lengths
  task automatic scan_display(output logic [27:0] segs, output logic [15:0] cnts, output int bad_an);
    segs   = '1;
    cnts   = '0;
    bad_an = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      case (bus.an)
        4'b1110: begin segs[6:0]   = bus.seg; cnts[3:0]   = cnts[3:0]   + 4'd1; end
        4'b1101: begin segs[13:7]  = bus.seg; cnts[7:4]   = cnts[7:4]   + 4'd1; end
        4'b1011: begin segs[20:14] = bus.seg; cnts[11:8]  = cnts[11:8]  + 4'd1; end
        4'b0111: begin segs[27:21] = bus.seg; cnts[15:12] = cnts[15:12] + 4'd1; end
        default: bad_an++;
      endcase
    end
  endtask

  task automatic set_score(input logic [31:0] v);
    @(negedge clk);
    bus.score = v;
  endtask

  task automatic settle();
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset();
    int busy_seen;
    logic [27:0] segs;
    logic [15:0] cnts;
    int bad_an;
    reset     = 1'b1;
    bus.score = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.an !== 4'b1110) begin n_bad++; $display("FAIL reset_an got %b want 1110", bus.an); end
    n_cmp++;
    if (bus.seg !== 7'h40) begin n_bad++; $display("FAIL reset_seg got %h want 40", bus.seg); end
    n_cmp++;
    if (bus.dp !== 1'b1) begin n_bad++; $display("FAIL reset_dp got %b want 1", bus.dp); end
    n_cmp++;
    if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
    reset = 1'b0;
    busy_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (dut.u_conv.busy === 1'b1) busy_seen++;
    end
    n_cmp++;
    if (busy_seen != 0) begin n_bad++; $display("FAIL reset_noconv busy_cycles=%0d want 0", busy_seen); end
    scan_display(segs, cnts, bad_an);
    n_cmp++;
    if (segs !== model_segs(0) || bad_an != 0) begin
      n_bad++; $display("FAIL reset_scan got %h badan=%0d want %h", segs, bad_an, model_segs(0));
    end
  endtask

  task automatic test_latency();
    logic [27:0] segs;
    logic [15:0] cnts;
    int bad_an;
    set_score(32'd5);
    repeat (16) @(negedge clk);
    n_cmp++;
    if (dut.bcd_q !== 16'h0000) begin n_bad++; $display("FAIL latency_e16 got %h want 0000", dut.bcd_q); end
    @(negedge clk);
    n_cmp++;
    if (dut.bcd_q !== 16'h0005) begin n_bad++; $display("FAIL latency_e17 got %h want 0005", dut.bcd_q); end
    settle();
    scan_display(segs, cnts, bad_an);
    n_cmp++;
    if (segs !== model_segs(5)) begin n_bad++; $display("FAIL scan_5 got %h want %h", segs, model_segs(5)); end
  endtask

  task automatic test_scan(input logic [31:0] v);
    logic [27:0] segs;
    logic [15:0] cnts;
    int bad_an;
    set_score(v);
    settle();
    scan_display(segs, cnts, bad_an);
    n_cmp++;
    if (segs !== model_segs(v) || bad_an != 0) begin
      n_bad++; $display("FAIL scan_%0d got %h badan=%0d want %h", v, segs, bad_an, model_segs(v));
    end
    n_cmp++;
    if (cnts !== 16'h4444) begin n_bad++; $display("FAIL slots_%0d got %h want 4444", v, cnts); end
    n_cmp++;
    if (bus.overflow !== (v > 32'd9999)) begin
      n_bad++; $display("FAIL ovf_%0d got %b want %b", v, bus.overflow, (v > 32'd9999));
    end
    n_cmp++;
    if (dut.bcd_q !== model_bcd(v)) begin
      n_bad++; $display("FAIL bcd_%0d got %h want %h", v, dut.bcd_q, model_bcd(v));
    end
  endtask

  task automatic test_overflow();
    test_scan(32'd12345);
    set_score(32'd42);
    repeat (16) @(negedge clk);
    n_cmp++;
    if (bus.overflow !== 1'b1 || dut.bcd_q !== 16'h9999) begin
      n_bad++; $display("FAIL ovf_hold_e16 got ovf=%b bcd=%h want 1/9999", bus.overflow, dut.bcd_q);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.overflow !== 1'b0 || dut.bcd_q !== 16'h0042) begin
      n_bad++; $display("FAIL ovf_clear_e17 got ovf=%b bcd=%h want 0/0042", bus.overflow, dut.bcd_q);
    end
    settle();
  endtask

  task automatic test_mid_shift();
    int first10, first11, mixed;
    set_score(32'd10);
    first10 = -1; first11 = -1; mixed = 0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      if (dut.bcd_q == 16'h0010 && first10 < 0) first10 = e;
      if (dut.bcd_q == 16'h0011 && first11 < 0) first11 = e;
      if (dut.bcd_q != 16'h0042 && dut.bcd_q != 16'h0010 && dut.bcd_q != 16'h0011) mixed++;
      if (e == 5) bus.score = 32'd11;
    end
    n_cmp++;
    if (first10 != 17) begin n_bad++; $display("FAIL mid_first10 edge got %0d want 17", first10); end
    n_cmp++;
    if (first11 < 18 || first11 > 34) begin n_bad++; $display("FAIL mid_first11 edge got %0d want 18..34", first11); end
    n_cmp++;
    if (mixed != 0) begin n_bad++; $display("FAIL mid_mixed got %0d cycles want 0", mixed); end
  endtask

  task automatic test_repeat();
    int busy_seen;
    set_score(32'd11);
    busy_seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (dut.u_conv.busy === 1'b1) busy_seen++;
    end
    n_cmp++;
    if (busy_seen != 0) begin n_bad++; $display("FAIL repeat_noconv busy_cycles=%0d want 0", busy_seen); end
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(0, 9999);
        2:       v = $urandom;
        default: v = $urandom_range(9990, 10010);
      endcase
      test_scan(v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 12; i++) begin
      v = (i % 3 == 2) ? $urandom : $urandom_range(0, 12000);
      set_score(v);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    settle();
    n_cmp++;
    if (dut.bcd_q !== model_bcd(v) || bus.overflow !== (v > 32'd9999)) begin
      n_bad++; $display("FAIL b2b_final got bcd=%h ovf=%b want %h/%b", dut.bcd_q, bus.overflow, model_bcd(v), (v > 32'd9999));
    end
  endtask

  task automatic test_reset_mid();
    test_scan(32'd20000);
    set_score(32'd567);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'h40 || bus.overflow !== 1'b0 || dut.bcd_q !== 16'h0000) begin
      n_bad++; $display("FAIL rstmid_vals got an=%b seg=%h ovf=%b bcd=%h want 1110/40/0/0000",
                        bus.an, bus.seg, bus.overflow, dut.bcd_q);
    end
    reset = 1'b0;
    repeat (16) @(negedge clk);
    n_cmp++;
    if (dut.bcd_q !== 16'h0000) begin n_bad++; $display("FAIL rstmid_e16 got %h want 0000", dut.bcd_q); end
    @(negedge clk);
    n_cmp++;
    if (dut.bcd_q !== 16'h0567 || bus.overflow !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_e17 got bcd=%h ovf=%b want 0567/0", dut.bcd_q, bus.overflow);
    end
    settle();
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    bus.score = '0;
    test_reset();
    test_latency();
    test_scan(32'd1234);
    test_scan(32'd1005);
    test_scan(32'd105);
    test_overflow();
    test_scan(32'd9999);
    test_scan(32'd10000);
    test_scan(32'd16384);
    test_scan(32'hFFFF_FFFF);
    test_scan(32'd42);
    test_mid_shift();
    test_repeat();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
